key_perm_stage: RTL and testbench

- Parametrised, flow-controlled successor to the fixed 4-word key-selected permutation stage of the pipelined cipher datapath.
- Reorders four lanes of LANE_W bits under a 2-bit selector taken from an internal key register.
- The key register can rotate two bits per accepted block, giving a per-block permutation stream.
- Sits between cipher round stages; valid/ready on both sides with a 2-entry (output + skid) buffer, so the pipeline never drops or duplicates a block under backpressure.

---
 rtl/key_perm_stage_pkg.sv | 25 ++
 rtl/key_perm_stage_lane_permute.sv | 20 ++
 rtl/key_perm_stage.sv | 101 ++++++++++
 tb/tb_key_perm_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_perm_stage_pkg.sv
// Shared cipher definitions: lane permutation table, selector type and
// output buffer state encoding for the key-selected permutation stage.
package key_perm_stage_pkg;

    typedef logic [1:0] sel_t;
    typedef logic [1:0] lane_idx_t;
    typedef logic [1:0] buf_state_t;

    localparam buf_state_t BUF_EMPTY = 2'd0;
    localparam buf_state_t BUF_ONE   = 2'd1;
    localparam buf_state_t BUF_FULL  = 2'd2;

    // PERM_TABLE[sel][k]: source lane (0=A .. 3=D) feeding output lane k (0=W .. 3=Z).
    localparam lane_idx_t PERM_TABLE [4][4] = '{
        '{2'd1, 2'd0, 2'd3, 2'd2},
        '{2'd3, 2'd1, 2'd2, 2'd0},
        '{2'd0, 2'd2, 2'd1, 2'd3},
        '{2'd0, 2'd3, 2'd2, 2'd1}
    };

    function automatic lane_idx_t perm_src(input sel_t sel, input lane_idx_t k);
        return PERM_TABLE[sel][k];
    endfunction

endpackage

// File: rtl/key_perm_stage_lane_permute.sv
// Combinational four-lane reorder selected by a 2-bit key selector.
module lane_permute
    import key_perm_stage_pkg::*;
#(
    parameter int unsigned LANE_W = 32
) (
    input  sel_t                sel,
    input  logic [4*LANE_W-1:0] in_data,
    output logic [4*LANE_W-1:0] out_data
);

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            out_data[k*LANE_W +: LANE_W] =
                in_data[int'(perm_src(sel, lane_idx_t'(k)))*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/key_perm_stage.sv
// Key-selected lane permutation stage with rotating key register and a
// two-entry (output + skid) valid/ready buffer.
module key_perm_stage
    import key_perm_stage_pkg::*;
#(
    parameter int unsigned LANE_W = 32,
    parameter int unsigned KEY_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*LANE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*LANE_W-1:0] out_data,
    input  logic                key_load,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                rot_en,
    output logic [CNT_W-1:0]    beat_cnt
);

    buf_state_t          buf_state;
    logic [KEY_W-1:0]    key_reg;
    logic [4*LANE_W-1:0] out_reg;
    logic [4*LANE_W-1:0] skid_reg;
    logic [4*LANE_W-1:0] perm_data;
    logic                accept;

    // Both flags decode the state register only, so in_ready never sees out_ready.
    assign out_valid = (buf_state != BUF_EMPTY);
    assign in_ready  = (buf_state != BUF_FULL);
    assign accept    = in_valid & in_ready;
    assign out_data  = out_reg;

    lane_permute #(
        .LANE_W (LANE_W)
    ) u_lane_permute (
        .sel      (key_reg[1:0]),
        .in_data  (in_data),
        .out_data (perm_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_state <= BUF_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else if (flush) begin
            buf_state <= BUF_EMPTY;
        end else begin
            case (buf_state)
                BUF_EMPTY: begin
                    if (accept) begin
                        out_reg   <= perm_data;
                        buf_state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && out_ready) begin
                        out_reg <= perm_data;
                    end else if (accept) begin
                        skid_reg  <= perm_data;
                        buf_state <= BUF_FULL;
                    end else if (out_ready) begin
                        buf_state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_ready) begin
                        out_reg   <= skid_reg;
                        buf_state <= BUF_ONE;
                    end
                end
                default: buf_state <= BUF_EMPTY;
            endcase
        end
    end

    // Shift form of rotate-right-by-2 stays legal when KEY_W == 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_reg <= '0;
        end else if (key_load) begin
            key_reg <= key_in;
        end else if (accept && rot_en && !flush) begin
            key_reg <= (key_reg >> 2) | (key_reg << (KEY_W - 2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_key_perm_stage.sv
// Scoreboard bench for key_perm_stage: stimulus pushes expected permuted
// blocks, a negedge monitor pops and compares on every output handshake.
module tb_key_perm_stage;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned KEY_W  = 16;
    localparam int unsigned CNT_W  = 4;

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic           key_load, rot_en;
    logic [127:0]   in_data, out_data;
    logic [15:0]    key_in;
    logic [3:0]     beat_cnt;

    int             checks = 0;
    int             fails  = 0;
    logic [127:0]   exp_q[$];

    always #5 clk = ~clk;

    key_perm_stage #(
        .LANE_W (LANE_W),
        .KEY_W  (KEY_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .key_load  (key_load),
        .key_in    (key_in),
        .rot_en    (rot_en),
        .beat_cnt  (beat_cnt)
    );

    function automatic logic [127:0] mk(input int unsigned i);
        logic [31:0] a, b, c, d;
        a = 32'h11111111 + i;
        b = 32'h22222222 + i;
        c = 32'h33333333 + i;
        d = 32'h44444444 + i;
        return {d, c, b, a};
    endfunction

    // Packed result is {Z,Y,X,W}.
    function automatic logic [127:0] perm(input logic [1:0] sel, input logic [127:0] x);
        logic [31:0] a, b, c, d;
        a = x[31:0];
        b = x[63:32];
        c = x[95:64];
        d = x[127:96];
        case (sel)
            2'd0:    return {c, d, a, b};
            2'd1:    return {a, c, b, d};
            2'd2:    return {d, b, c, a};
            default: return {b, c, d, a};
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] exp);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'(1));
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out: got %h expected no output", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        key_load = 1'b0; rot_en = 1'b0; in_data = '0; key_in = '0;
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_out_data",  out_data,        128'(0));
        check("rst_beat_cnt",  128'(beat_cnt),  128'(0));
        check("rst_key_reg",   128'(dut.key_reg), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: single block, key 0
        send(mk(0), 128'h33333333_44444444_11111111_22222222);
        check("t1_latency_valid", 128'(out_valid), 128'(1));
        idle(2);
        check("t1_beat_cnt", 128'(beat_cnt), 128'(1));

        // 2: rotating key 0x00E4 -> sel 0,1,2,3 then four more at sel 0
        rot_en = 1'b1; key_load = 1'b1; key_in = 16'h00E4;
        idle(1);
        key_load = 1'b0;
        check("t2_key_loaded", 128'(dut.key_reg), 128'(16'h00E4));
        for (int i = 0; i < 4; i++) send(mk(1 + i), perm(2'(i), mk(1 + i)));
        for (int i = 0; i < 4; i++) send(mk(5 + i), perm(2'd0, mk(5 + i)));
        check("t2_key_restored", 128'(dut.key_reg), 128'(16'h00E4));
        idle(2);
        check("t2_beat_cnt", 128'(beat_cnt), 128'(9));

        // 3: backpressure, third block held off until release
        rot_en = 1'b0; out_ready = 1'b0;
        send(mk(10), perm(2'd0, mk(10)));
        send(mk(11), perm(2'd0, mk(11)));
        check("t3_in_ready_full", 128'(in_ready), 128'(0));
        in_valid = 1'b1; in_data = mk(12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", 128'(in_ready), 128'(0));
            check("t3_stall_data",  out_data, perm(2'd0, mk(10)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk(12), perm(2'd0, mk(12)));
        idle(3);
        check("t3_beat_cnt", 128'(beat_cnt), 128'(12));

        // 4: key_load during accept; accepted block uses old sel 1
        key_load = 1'b1; key_in = 16'h0001;
        idle(1);
        key_load = 1'b0;
        rot_en = 1'b1; key_load = 1'b1; key_in = 16'h0003;
        send(mk(20), perm(2'd1, mk(20)));
        key_load = 1'b0;
        check("t4_load_wins", 128'(dut.key_reg), 128'(16'h0003));
        send(mk(21), perm(2'd3, mk(21)));
        check("t4_rotated", 128'(dut.key_reg), 128'(16'hC000));
        idle(2);
        check("t4_beat_cnt", 128'(beat_cnt), 128'(14));

        // 5: flush with FULL buffer
        rot_en = 1'b0; out_ready = 1'b0;
        send(mk(30), perm(2'd0, mk(30)));
        send(mk(31), perm(2'd0, mk(31)));
        check("t5_full", 128'(in_ready), 128'(0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        check("t5_out_valid", 128'(out_valid), 128'(0));
        check("t5_in_ready",  128'(in_ready),  128'(1));
        check("t5_key_reg",   128'(dut.key_reg), 128'(16'hC000));
        check("t5_beat_cnt",  128'(beat_cnt),  128'(14));
        out_ready = 1'b1;
        idle(2);
        check("t5_stays_empty", 128'(out_valid), 128'(0));

        // asynchronous reset mid-operation drops the buffered block
        out_ready = 1'b0;
        send(mk(40), perm(2'd0, mk(40)));
        check("rst2_pre_valid", 128'(out_valid), 128'(1));
        #2 reset = 1'b1;
        #1;
        check("rst2_out_valid", 128'(out_valid), 128'(0));
        check("rst2_out_data",  out_data,        128'(0));
        check("rst2_beat_cnt",  128'(beat_cnt),  128'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;

        // 6: counter wrap at CNT_W=4
        for (int i = 0; i < 16; i++) send(mk(50 + i), perm(2'd0, mk(50 + i)));
        idle(2);
        check("t6_wrap_zero", 128'(beat_cnt), 128'(0));
        send(mk(66), perm(2'd0, mk(66)));
        idle(2);
        check("t6_wrap_one", 128'(beat_cnt), 128'(1));

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
